// File: rtl/ycbcr422_pkg.sv
// rtl/ycbcr422_pkg.sv - shared constants and phase encoding for the 4:4:4 to 4:2:2 converter
package ycbcr422_pkg;

  localparam int YCBCR_WIDTH_DEF = 12;

  localparam logic C_SEL_CB = 1'b0;
  localparam logic C_SEL_CR = 1'b1;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

endpackage

// File: rtl/chroma_avg.sv
// rtl/chroma_avg.sv - rounded (half up) average of two unsigned samples
module chroma_avg #(
  parameter int W = 12
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_avg
);

  // One extra bit holds the full sum plus the rounding bit without overflow.
  logic [W:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, 1'b1};
  assign o_avg = w_sum[W:1];

endmodule

// File: rtl/ycbcr444_to_422.sv
// rtl/ycbcr444_to_422.sv - 4:4:4 to 4:2:2 YCbCr horizontal chroma decimator
module ycbcr444_to_422
  import ycbcr422_pkg::*;
#(
  parameter int YCbCr_WIDTH = YCBCR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_data_enable,
  input  logic                   i_sol,
  input  logic                   i_eol,
  input  logic [YCbCr_WIDTH-1:0] y,
  input  logic [YCbCr_WIDTH-1:0] cb,
  input  logic [YCbCr_WIDTH-1:0] cr,
  output logic                   o_data_valid,
  output logic [YCbCr_WIDTH-1:0] o_y,
  output logic [YCbCr_WIDTH-1:0] o_c,
  output logic                   o_c_sel,
  output logic                   o_sol,
  output logic                   o_eol,
  output logic                   o_err
);

  localparam int W = YCbCr_WIDTH;

  phase_t r_phase;
  phase_t w_phase_nxt;
  logic   w_capture;
  logic   w_pair_done;
  logic   w_single;
  logic   w_err_set;

  // Held even pixel P0
  logic [W-1:0] r_h_y, r_h_cb, r_h_cr;
  logic         r_h_sol;

  // Pair-result stage: first slot is always a Cb sample of a completed pair,
  // second slot is either the Cr sample of that pair or a lone eol sample.
  logic         r_pr_first;
  logic [W-1:0] r_pr_y0, r_pr_c0;
  logic         r_pr_sol0;
  logic         r_pr_second;
  logic [W-1:0] r_pr_y1, r_pr_c1;
  logic         r_pr_sel1, r_pr_sol1, r_pr_eol1;

  // Pending second sample, presented one cycle after the first
  logic         r_pd_vld;
  logic [W-1:0] r_pd_y, r_pd_c;
  logic         r_pd_sel, r_pd_sol, r_pd_eol;

  logic [W-1:0] w_cb_avg, w_cr_avg;

  chroma_avg #(.W(W)) u_cb_avg (.i_a(r_h_cb), .i_b(cb), .o_avg(w_cb_avg));
  chroma_avg #(.W(W)) u_cr_avg (.i_a(r_h_cr), .i_b(cr), .o_avg(w_cr_avg));

  // Phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_phase <= PH_EVEN;
    else        r_phase <= w_phase_nxt;
  end

  // Next phase and per-pixel action decode
  always_comb begin
    w_phase_nxt = r_phase;
    w_capture   = 1'b0;
    w_pair_done = 1'b0;
    w_single    = 1'b0;
    w_err_set   = 1'b0;
    if (i_data_enable) begin
      if (r_phase == PH_ODD && !i_sol) begin
        w_pair_done = 1'b1;
        w_phase_nxt = PH_EVEN;
      end else begin
        // EVEN, or ODD restarted by a new sol (held pixel is abandoned)
        w_err_set = (r_phase == PH_ODD);
        if (i_eol) begin
          w_single    = 1'b1;
          w_phase_nxt = PH_EVEN;
        end else begin
          w_capture   = 1'b1;
          w_phase_nxt = PH_ODD;
        end
      end
    end
  end

  // Capture of the even pixel, pair results and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_y       <= '0;
      r_h_cb      <= '0;
      r_h_cr      <= '0;
      r_h_sol     <= 1'b0;
      r_pr_first  <= 1'b0;
      r_pr_y0     <= '0;
      r_pr_c0     <= '0;
      r_pr_sol0   <= 1'b0;
      r_pr_second <= 1'b0;
      r_pr_y1     <= '0;
      r_pr_c1     <= '0;
      r_pr_sel1   <= C_SEL_CB;
      r_pr_sol1   <= 1'b0;
      r_pr_eol1   <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      r_pr_first  <= w_pair_done;
      r_pr_second <= w_pair_done | w_single;
      if (w_capture) begin
        r_h_y   <= y;
        r_h_cb  <= cb;
        r_h_cr  <= cr;
        r_h_sol <= i_sol;
      end
      if (w_pair_done) begin
        r_pr_y0   <= r_h_y;
        r_pr_c0   <= w_cb_avg;
        r_pr_sol0 <= r_h_sol;
        r_pr_y1   <= y;
        r_pr_c1   <= w_cr_avg;
        r_pr_sel1 <= C_SEL_CR;
        r_pr_sol1 <= 1'b0;
        r_pr_eol1 <= i_eol;
      end else if (w_single) begin
        r_pr_y1   <= y;
        r_pr_c1   <= cb;
        r_pr_sel1 <= C_SEL_CB;
        r_pr_sol1 <= i_sol;
        r_pr_eol1 <= 1'b1;
      end
      if (w_err_set) o_err <= 1'b1;
    end
  end

  // Pending-second-sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pd_vld <= 1'b0;
      r_pd_y   <= '0;
      r_pd_c   <= '0;
      r_pd_sel <= C_SEL_CB;
      r_pd_sol <= 1'b0;
      r_pd_eol <= 1'b0;
    end else begin
      r_pd_vld <= r_pr_second;
      if (r_pr_second) begin
        r_pd_y   <= r_pr_y1;
        r_pd_c   <= r_pr_c1;
        r_pd_sel <= r_pr_sel1;
        r_pd_sol <= r_pr_sol1;
        r_pd_eol <= r_pr_eol1;
      end
    end
  end

  // Output stage; a pair's first sample and a pending sample never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data_valid <= 1'b0;
      o_y          <= '0;
      o_c          <= '0;
      o_c_sel      <= C_SEL_CB;
      o_sol        <= 1'b0;
      o_eol        <= 1'b0;
    end else if (r_pr_first) begin
      o_data_valid <= 1'b1;
      o_y          <= r_pr_y0;
      o_c          <= r_pr_c0;
      o_c_sel      <= C_SEL_CB;
      o_sol        <= r_pr_sol0;
      o_eol        <= 1'b0;
    end else if (r_pd_vld) begin
      o_data_valid <= 1'b1;
      o_y          <= r_pd_y;
      o_c          <= r_pd_c;
      o_c_sel      <= r_pd_sel;
      o_sol        <= r_pd_sol;
      o_eol        <= r_pd_eol;
    end else begin
      o_data_valid <= 1'b0;
      o_sol        <= 1'b0;
      o_eol        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ycbcr444_to_422.sv
// tb/tb_ycbcr444_to_422.sv - randomized and directed self-checking bench for ycbcr444_to_422
module tb_ycbcr444_to_422;

  localparam int W = 12;

  typedef struct packed {
    logic [W-1:0] y;
    logic [W-1:0] c;
    logic         sel;
    logic         sol;
    logic         eol;
  } samp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         d_en = 1'b0, d_sol = 1'b0, d_eol = 1'b0;
  logic [W-1:0] d_y = '0, d_cb = '0, d_cr = '0;
  logic         o_data_valid, o_c_sel, o_sol, o_eol, o_err;
  logic [W-1:0] o_y, o_c;

  int n_chk = 0;
  int n_fail = 0;
  int e = 0;
  int n_valid = 0;

  samp_t exp_q [int];
  samp_t got [$];
  samp_t last_s = '0;
  bit    m_err = 0;
  bit    h_vld = 0;
  int    h_y, h_cb, h_cr;
  bit    h_sol;

  ycbcr444_to_422 #(.YCbCr_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_data_enable(d_en), .i_sol(d_sol), .i_eol(d_eol),
    .y(d_y), .cb(d_cb), .cr(d_cr),
    .o_data_valid(o_data_valid), .o_y(o_y), .o_c(o_c), .o_c_sel(o_c_sel),
    .o_sol(o_sol), .o_eol(o_eol), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: schedules each expected sample at the edge it must appear after
  always @(posedge clk) begin
    e++;
    if (rst_n && d_en) begin
      if (h_vld && !d_sol) begin
        exp_q[e+1] = '{y: W'(h_y), c: W'((h_cb + int'(d_cb) + 1) / 2), sel: 1'b0, sol: h_sol, eol: 1'b0};
        exp_q[e+2] = '{y: d_y, c: W'((h_cr + int'(d_cr) + 1) / 2), sel: 1'b1, sol: 1'b0, eol: d_eol};
        h_vld = 0;
      end else begin
        if (h_vld) m_err = 1;
        h_vld = 0;
        if (d_eol) begin
          exp_q[e+2] = '{y: d_y, c: d_cb, sel: 1'b0, sol: d_sol, eol: 1'b1};
        end else begin
          h_vld = 1; h_y = int'(d_y); h_cb = int'(d_cb); h_cr = int'(d_cr); h_sol = d_sol;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    h_vld = 0;
    m_err = 0;
    last_s = '0;
  end

  // Compare process: every cycle, every output
  always @(negedge clk) begin
    logic [31:0] act, req;
    samp_t s;
    act = {4'b0, o_data_valid, o_y, o_c, o_c_sel, o_sol, o_eol};
    if (!rst_n) begin
      req = '0;
    end else if (exp_q.exists(e)) begin
      s = exp_q[e];
      exp_q.delete(e);
      last_s = s;
      req = {4'b0, 1'b1, s};
    end else begin
      req = {4'b0, 1'b0, last_s.y, last_s.c, last_s.sel, 2'b00};
    end
    chk("stream", act, req);
    chk("err", {31'b0, o_err}, {31'b0, m_err});
    if (o_data_valid) begin
      got.push_back('{y: o_y, c: o_c, sel: o_c_sel, sol: o_sol, eol: o_eol});
      n_valid++;
    end
  end

  task automatic px(input bit en, input bit sol, input bit eol, input int yy, input int cbv, input int crv);
    @(negedge clk);
    d_en = en; d_sol = sol; d_eol = eol;
    d_y = W'(yy); d_cb = W'(cbv); d_cr = W'(crv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_samp(input string nm, input int idx, input int yy, input int c, input bit sel, input bit sol, input bit eol);
    samp_t r;
    r = '{y: W'(yy), c: W'(c), sel: sel, sol: sol, eol: eol};
    if (idx < got.size()) chk(nm, {5'b0, got[idx]}, {5'b0, r});
    else chk({nm, "_missing"}, got.size(), idx + 1);
  endtask

  initial begin
    int ys[4], cbs[4], crs[4];
    ys = '{10, 20, 30, 40}; cbs = '{100, 101, 200, 200}; crs = '{50, 53, 7, 8};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Back-to-back 4-pixel line
    got.delete();
    for (int i = 0; i < 4; i++) px(1, i == 0, i == 3, ys[i], cbs[i], crs[i]);
    idle(5);
    chk("t1_count", got.size(), 4);
    chk_samp("t1_s0", 0, 10, 101, 0, 1, 0);
    chk_samp("t1_s1", 1, 20, 52, 1, 0, 0);
    chk_samp("t1_s2", 2, 30, 200, 0, 0, 0);
    chk_samp("t1_s3", 3, 40, 8, 1, 0, 1);

    // Same line with idle gaps
    got.delete();
    for (int i = 0; i < 4; i++) begin px(1, i == 0, i == 3, ys[i], cbs[i], crs[i]); idle(1); end
    idle(5);
    chk("t2_count", got.size(), 4);
    chk_samp("t2_s1", 1, 20, 52, 1, 0, 0);

    // 3-pixel line followed immediately by a new line
    got.delete();
    px(1, 1, 0, 1, 2, 3); px(1, 0, 0, 4, 6, 7); px(1, 0, 1, 5, 9, 11);
    px(1, 1, 0, 60, 10, 10); px(1, 0, 1, 61, 11, 11);
    idle(5);
    chk_samp("t3_single", 2, 5, 9, 0, 0, 1);
    chk("t3_err", o_err, 0);

    // sol on second pixel of a pair
    got.delete();
    px(1, 1, 0, 1, 50, 50); px(1, 1, 0, 2, 10, 30); px(1, 0, 0, 3, 20, 41); px(1, 0, 1, 4, 77, 5);
    idle(5);
    chk("t4_count", got.size(), 3);
    chk_samp("t4_s0", 0, 2, 15, 0, 1, 0);
    chk_samp("t4_s1", 1, 3, 36, 1, 0, 0);
    chk("t4_err", o_err, 1);

    // Extremes and round-half-up
    got.delete();
    px(1, 1, 0, 4095, 4095, 0); px(1, 0, 1, 4095, 4095, 1);
    px(1, 1, 0, 0, 0, 4094); px(1, 0, 1, 0, 1, 4095);
    idle(5);
    chk_samp("t5_max", 0, 4095, 4095, 0, 1, 0);
    chk_samp("t5_cr01", 1, 4095, 1, 1, 0, 1);
    chk_samp("t5_cb01", 2, 0, 1, 0, 1, 0);
    chk_samp("t5_cr_hi", 3, 0, 4095, 1, 0, 1);
    chk("t5_err_sticky", o_err, 1);

    // Asynchronous reset with a held pixel and a pending second sample
    px(1, 1, 0, 7, 7, 7); px(1, 0, 0, 8, 8, 8); px(1, 1, 0, 9, 9, 9);
    @(posedge clk);
    #2 rst_n = 1'b0; d_en = 1'b0;
    #1 chk("t6_async_zero", {o_data_valid, o_y, o_c, o_c_sel, o_sol, o_eol, o_err}, '0);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    got.delete();
    n_valid = 0;
    px(1, 1, 0, 100, 40, 60); px(1, 0, 1, 101, 41, 61);
    idle(6);
    chk("t6_count", n_valid, 2);
    chk_samp("t6_s0", 0, 100, 41, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int v;
      v = ($urandom_range(0, 9) == 0) ? 4095 : int'($urandom_range(0, 4095));
      px($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
         $urandom_range(0, 4095), v, $urandom_range(0, 4095));
    end
    idle(6);
    chk("rand_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
